dec_normalizer_seq: RTL
=======================

Name: dec_normalizer_seq

Overview:
- Sequential, parametrised leading-zero normalizer for the two BCD operands of the decimal subtractor.
- Removes leading zero digits one digit per cycle, decrementing each exponent per shift.
- Each shift is bounded by that channel's exponent (floor 0) and by the digit count.
- Sits between operand unpack and alignment, behind a valid/ready handshake on both sides.

Parameters:
- NDIG, 7, BCD digits per mantissa; mantissa width MW = 4*NDIG; NDIG >= 2.
- EW, 8, exponent width (unsigned).
- SW, $clog2(NDIG), width of the shift-count outputs.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  operand pair presented.
- in_ready  out  1  block can accept an operand pair.
- e1_in, e2_in  in  EW  exponents.
- m1_in, m2_in  in  MW  BCD mantissas, most significant digit at [MW-1:MW-4].
- out_valid  out  1  result pair valid.
- out_ready  in  1  consumer accepts the result.
- e1_out, e2_out  out  EW  adjusted exponents.
- m1_out, m2_out  out  MW  normalized mantissas.
- sh1, sh2  out  SW  digits shifted per channel.
- zero1, zero2  out  1  mantissa was all zero.
- lim1, lim2  out  1  shifting stopped because the exponent reached 0 while the MSD was still 0.

Behaviour:
- Single clock. All state is updated on the clk rising edge.
- Synchronous active-low reset: state=IDLE; all output registers, counters and flags are 0; out_valid=0.
- in_ready = (state==IDLE) && rst_n.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On in_valid && in_ready, capture the operands into the working registers.
  - Clear sh*, zero* and lim*. Go to SHIFT.
- SHIFT, per channel c, evaluated each cycle:
  - need_c = (m_c != 0) && (MSD_c == 0) && (e_c != 0) && (sh_c < NDIG-1).
  - If need_c: m_c <= m_c << 4; e_c <= e_c - 1; sh_c <= sh_c + 1.
  - The two channels are independent. A channel that is finished holds its value while the other continues.
  - When neither channel needs a shift, go to DONE and set out_valid <= 1.
  - On that same edge: zero_c <= (m_c == 0); lim_c <= (m_c != 0) && (MSD_c == 0) && (e_c == 0).
- Latency from the accept edge to out_valid=1 is max(sh1,sh2)+1 cycles. The minimum is 1 cycle and the maximum is NDIG cycles.
- DONE:
  - out_valid=1. All outputs are held stable until out_ready=1.
  - On out_ready, out_valid <= 0 and go to IDLE.
  - No new input is accepted in the same cycle.
- All-zero mantissa: no shift, exponent unchanged, zero_c=1, lim_c=0.
- Exponent decrement never wraps, because a shift requires e_c != 0.
- Outputs are driven directly from the working registers. Their values are don't-care while out_valid=0, and the bench must not check them then.
- in_valid during SHIFT or DONE is ignored; operands are not latched.
- out_ready while out_valid=0 has no effect.
- Reset asserted in any state wins over every other event on that edge.

Test Plan (NDIG=7, EW=8 unless noted):
- Basic shift:
  - Stimulus: m1=28'h0001234, e1=10; m2=28'h1234567, e2=5.
  - Required: m1_out=28'h1234000, e1_out=7, sh1=3; m2_out/e2_out unchanged, sh2=0; out_valid 4 cycles after accept.
- Exponent limit:
  - Stimulus: m1=28'h0000012, e1=2; m2=28'h0000300, e2=50.
  - Required: m1_out=28'h0001200, e1_out=0, lim1=1, sh1=2; m2_out=28'h3000000, e2_out=46, sh2=4, lim2=0; latency 5.
- Zero and maximum shift:
  - Stimulus A: m1=0, e1=9; m2=28'h0000005, e2=200.
  - Required A: zero1=1, e1_out=9, m1_out=0; m2_out=28'h5000000, e2_out=194, sh2=6; latency 7.
  - Stimulus B: both mantissas 0.
  - Required B: latency 1.
- Handshake and backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles in DONE while toggling in_valid with new operands.
  - Required: outputs stable, in_ready=0, new operands not captured.
  - Then out_ready=1: out_valid=0 next cycle and in_ready=1; the next operand pair is processed correctly.
- Reset mid-operation:
  - Stimulus: drive rst_n=0 for one cycle during SHIFT with sh1=2.
  - Required: on the next cycle state=IDLE, out_valid=0, all outputs 0, in_ready=1 after rst_n returns high.
  - A subsequent transaction completes normally.
- Parameter sweep:
  - Stimulus: NDIG=16, EW=10, m1=64'h0000000000000001, e1=1023.
  - Required: m1_out=64'h1000000000000000, e1_out=1008, sh1=15; latency 16.

Source files
------------

// File: rtl/dec_normalizer_seq.sv
// Sequential leading-zero normalizer for the two BCD operands of the decimal subtractor.
// One digit shift per cycle per channel, bounded by exponent (floor 0) and by NDIG-1 shifts.

module dec_norm_lane #(
  parameter int NDIG = 7,
  parameter int EW   = 8,
  parameter int SW   = $clog2(NDIG),
  parameter int MW   = 4*NDIG
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic          i_run,
  input  logic          i_fin,
  input  logic [EW-1:0] i_e,
  input  logic [MW-1:0] i_m,
  output logic          o_need,
  output logic [EW-1:0] o_e,
  output logic [MW-1:0] o_m,
  output logic [SW-1:0] o_sh,
  output logic          o_zero,
  output logic          o_lim
);
  localparam logic [SW-1:0] SH_MAX = SW'(NDIG-1);

  logic [EW-1:0] r_e;
  logic [MW-1:0] r_m;
  logic [SW-1:0] r_sh;
  logic          r_zero, r_lim;
  logic          w_mnz, w_msd_z;

  assign w_mnz   = |r_m;
  assign w_msd_z = (r_m[MW-1:MW-4] == 4'd0);
  // sh only counts up from 0, so "!= max" is the same bound as "< NDIG-1"
  assign o_need  = w_mnz && w_msd_z && (r_e != '0) && (r_sh != SH_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_e <= '0; r_m <= '0; r_sh <= '0; r_zero <= 1'b0; r_lim <= 1'b0;
    end else if (i_load) begin
      r_e <= i_e; r_m <= i_m; r_sh <= '0; r_zero <= 1'b0; r_lim <= 1'b0;
    end else if (i_run) begin
      if (o_need) begin
        r_m  <= r_m << 4;
        r_e  <= r_e - 1'b1;
        r_sh <= r_sh + 1'b1;
      end
      if (i_fin) begin
        r_zero <= !w_mnz;
        r_lim  <= w_mnz && w_msd_z && (r_e == '0);
      end
    end
  end

  assign o_e    = r_e;
  assign o_m    = r_m;
  assign o_sh   = r_sh;
  assign o_zero = r_zero;
  assign o_lim  = r_lim;
endmodule

module dec_normalizer_seq #(
  parameter  int NDIG = 7,
  parameter  int EW   = 8,
  parameter  int SW   = $clog2(NDIG),
  localparam int MW   = 4*NDIG
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [EW-1:0] e1_in,
  input  logic [EW-1:0] e2_in,
  input  logic [MW-1:0] m1_in,
  input  logic [MW-1:0] m2_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [EW-1:0] e1_out,
  output logic [EW-1:0] e2_out,
  output logic [MW-1:0] m1_out,
  output logic [MW-1:0] m2_out,
  output logic [SW-1:0] sh1,
  output logic [SW-1:0] sh2,
  output logic          zero1,
  output logic          zero2,
  output logic          lim1,
  output logic          lim2
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t r_state;
  logic   r_out_valid;

  logic [1:0][EW-1:0] w_e_in, w_e;
  logic [1:0][MW-1:0] w_m_in, w_m;
  logic [1:0][SW-1:0] w_sh;
  logic [1:0]         w_need, w_zero, w_lim;
  logic               w_acc, w_run, w_fin;

  assign in_ready = (r_state == IDLE) && rst_n;
  assign w_acc    = in_valid && in_ready;
  assign w_run    = (r_state == SHIFT);
  assign w_fin    = w_run && !(|w_need);

  assign w_e_in = {e2_in, e1_in};
  assign w_m_in = {m2_in, m1_in};

  for (genvar c = 0; c < 2; c++) begin : g_lane
    dec_norm_lane #(.NDIG(NDIG), .EW(EW), .SW(SW), .MW(MW)) u_lane (
      .clk(clk), .rst_n(rst_n), .i_load(w_acc), .i_run(w_run), .i_fin(w_fin),
      .i_e(w_e_in[c]), .i_m(w_m_in[c]), .o_need(w_need[c]), .o_e(w_e[c]),
      .o_m(w_m[c]), .o_sh(w_sh[c]), .o_zero(w_zero[c]), .o_lim(w_lim[c])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE:  if (w_acc) r_state <= SHIFT;
        SHIFT: if (w_fin) begin
          r_state     <= DONE;
          r_out_valid <= 1'b1;
        end
        DONE:  if (out_ready) begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign e1_out = w_e[0];   assign e2_out = w_e[1];
  assign m1_out = w_m[0];   assign m2_out = w_m[1];
  assign sh1    = w_sh[0];  assign sh2    = w_sh[1];
  assign zero1  = w_zero[0]; assign zero2 = w_zero[1];
  assign lim1   = w_lim[0];  assign lim2  = w_lim[1];
endmodule
